// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the eight-digit stopwatch display.
// Holds the converter state type, digit count, display range limit and
// the active-low segment patterns ({g,f,e,d,c,b,a}) for 0..9, blank and dash.
package sevenseg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } conv_state_t;

   localparam int NUM_DIGITS = 8;
   localparam int BIN_W      = 32;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [BIN_W-1:0] MAX_VALUE = 32'd99_999_999;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit BCD converter (shift-add-3).
// Ports:
//   clk, resetn : system clock, async active-low reset
//   start       : accepted only in IDLE; captures bin
//   bin         : binary input, sampled on an accepted start
//   busy        : high in LOAD and SHIFT
//   done        : one-cycle pulse in COMMIT, bcd/overflow valid with it
//   bcd         : packed BCD result, digit k in bits [4k+3:4k]
//   overflow    : captured value exceeds the displayable range
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | copy captured value into shifter, clear BCD accumulator
// SHIFT  | 32 adjust-then-shift steps, bit_cnt counts down to 0
// COMMIT | result stable for one cycle, done asserted
module bin2bcd_seq
   import sevenseg_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic             overflow
);

   conv_state_t      state_q, state_nxt;
   logic [BIN_W-1:0] bin_q;
   logic [BIN_W-1:0] sh_q;
   logic [BCD_W-1:0] bcd_q, bcd_adj;
   logic [4:0]       bit_cnt_q;

   always_comb begin
      state_nxt = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            busy      = 1'b1;
            state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (bit_cnt_q == 5'd0) state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Nibbles >= 5 become >= 10 after the shift, so they are pre-corrected.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         sh_q      <= '0;
         bcd_q     <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            ST_IDLE: begin
               if (start) bin_q <= bin;
            end
            ST_LOAD: begin
               sh_q      <= bin_q;
               bcd_q     <= '0;
               bit_cnt_q <= 5'd31;
            end
            ST_SHIFT: begin
               {bcd_q, sh_q} <= {bcd_adj, sh_q} << 1;
               bit_cnt_q     <= bit_cnt_q - 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign bcd      = bcd_q;
   assign overflow = (bin_q > MAX_VALUE);

endmodule

// File: rtl/sevenseg_display.sv
// Eight-digit multiplexed seven-segment stopwatch display (SSSSS.hh).
// Ports:
//   clk, resetn : system clock, async active-low reset
//   value       : stopwatch count in hundredths, captured once per frame
//   an          : active-low digit anodes, an[0] is the rightmost digit
//   seg         : active-low cathodes {g,f,e,d,c,b,a}
//   dp          : active-low decimal point, lit after digit 2
//   busy        : conversion in progress
module sevenseg_display
   import sevenseg_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int DIGIT_HZ = 1000
)
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] value,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        busy
);

   localparam int DIV   = CLK_HZ / DIGIT_HZ;
   localparam int DIV_W = $clog2(DIV);

   logic [DIV_W-1:0] div_q;
   logic [2:0]       digit_q;
   logic             run_q;
   logic             div_wrap;
   logic             frame_start;

   logic             conv_done;
   logic             conv_ovf;
   logic [BCD_W-1:0] conv_bcd;

   logic [BCD_W-1:0] disp_bcd_q;
   logic             disp_valid_q;
   logic             disp_ovf_q;

   logic [3:0]       cur_nib;
   logic             cur_blank;

   assign div_wrap    = (div_q == DIV_W'(DIV - 1));
   assign frame_start = div_wrap && (digit_q == 3'd7);

   // run_q keeps all anodes off until the first clock after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q   <= '0;
         digit_q <= '0;
         run_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (div_wrap) begin
            div_q   <= '0;
            digit_q <= digit_q + 3'd1;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk      (clk),
      .resetn   (resetn),
      .start    (frame_start),
      .bin      (value),
      .busy     (busy),
      .done     (conv_done),
      .bcd      (conv_bcd),
      .overflow (conv_ovf)
   );

   // Display contents change only on done, so a scan never mixes frames.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disp_bcd_q   <= '0;
         disp_valid_q <= 1'b0;
         disp_ovf_q   <= 1'b0;
      end else if (conv_done) begin
         disp_bcd_q   <= conv_bcd;
         disp_valid_q <= 1'b1;
         disp_ovf_q   <= conv_ovf;
      end
   end

   always_comb begin
      an        = 8'hFF;
      seg       = SEG_BLANK;
      dp        = 1'b1;
      cur_nib   = disp_bcd_q[{digit_q, 2'b00} +: 4];
      cur_blank = 1'b0;
      // Upper five digits blank only while they and every digit above are zero.
      if (digit_q >= 3'd3) begin
         cur_blank = 1'b1;
         for (int i = 3; i < NUM_DIGITS; i++) begin
            if (i >= int'(digit_q) && disp_bcd_q[4*i +: 4] != 4'd0) cur_blank = 1'b0;
         end
      end
      if (run_q) begin
         an[digit_q] = 1'b0;
         if (disp_valid_q) begin
            if (disp_ovf_q) begin
               seg = SEG_DASH;
            end else begin
               seg = cur_blank ? SEG_BLANK : seg_encode(cur_nib);
               dp  = (digit_q != 3'd2);
            end
         end
      end
   end

endmodule

// File: doc/sevenseg_display.md
SEVENSEG_DISPLAY -- requirements
Module: sevenseg_display

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter DIGIT_HZ, default 1000, per-digit scan rate; digit period DIV = CLK_HZ/DIGIT_HZ cycles, DIV >= 40 SHALL hold.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 value  input  32  unsigned stopwatch count in hundredths of a second, asynchronous to frames, sampled only as in REQ-011.
REQ-006 an  output  8  digit anodes, active-low, an[k] = digit k, digit 0 rightmost.
REQ-007 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  output  1  decimal point cathode, active-low.
REQ-009 busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-010 The scan divider SHALL count 0..DIV-1 and advance digit index 0->1->...->7->0 on each wrap; exactly one an bit SHALL be low at any time outside reset.
REQ-011 On each frame start (digit index 7->0 transition) the block SHALL capture value into an input register and start a conversion.
REQ-012 Conversion FSM states: IDLE, LOAD, SHIFT, COMMIT; IDLE->LOAD on frame start, LOAD->SHIFT after 1 cycle, SHIFT for exactly 32 cycles, COMMIT 1 cycle, then IDLE.
REQ-013 SHIFT SHALL implement shift-add-3 (double dabble): before each shift, every 4-bit BCD nibble >= 5 gets +3; 32-bit binary, 32-bit (8-nibble) BCD result.
REQ-014 Latency from frame start to committed display SHALL be 34 cycles; busy high in LOAD and SHIFT, low in IDLE and COMMIT.
REQ-015 The displayed digit register SHALL update atomically in COMMIT only; digits shown mid-conversion SHALL be the previous committed frame.
REQ-016 If the captured value > 99_999_999, COMMIT SHALL load overflow mode: all 8 digits show dash (seg = 7'b0111111), dp off.
REQ-017 Leading-zero blanking SHALL apply to digits 7..3 only: a digit is blank (seg = 7'b1111111) if it and all higher digits are zero; digits 2..0 always shown.
REQ-018 dp SHALL be low only while digit 2 is active and not in overflow mode (format SSSSS.hh).
REQ-019 Decimal encoding 0..9 SHALL be the standard common-anode patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-020 A frame start arriving while busy SHALL be ignored (no restart, no capture); given DIV >= 40 this SHALL not occur in normal operation.
REQ-021 Changes on value between frame starts SHALL have no effect on outputs.

Reset
REQ-022 While resetn low: an = 8'hFF, seg = 7'h7F, dp = 1, busy = 0, FSM = IDLE, scan divider and digit index = 0, committed display = all blank, not overflow.
REQ-023 Reset asserted mid-conversion SHALL abort it; after release the first frame start begins a fresh conversion.
REQ-024 After resetn rises, outputs SHALL remain all-blank until the first COMMIT.

Structure
REQ-025 Package sevenseg_pkg SHALL hold: FSM state type, NUM_DIGITS = 8, MAX_VALUE = 99_999_999, segment constants for 0..9, BLANK, DASH.
REQ-026 The double-dabble converter (LOAD/SHIFT/COMMIT, start/done handshake) SHALL be a sub-module bin2bcd_seq; scan, blanking and encoding remain in sevenseg_display.

Verification (DIV = 40 for simulation)
REQ-027 value = 0, run 2 frames -> digits 2..0 show "0","0","0", dp low on digit 2, digits 7..3 blank.
REQ-028 value = 123_456 -> digits 5..0 show 1,2,3,4,5,6, digits 7..6 blank, dp on digit 2, busy high exactly 33 cycles per frame.
REQ-029 value = 99_999_999 -> all eight digits show 9; value = 100_000_000 -> all eight digits DASH, dp never low.
REQ-030 value changed from 5 to 77 at cycle 10 of a conversion -> that frame commits 5, next frame commits 77.
REQ-031 resetn pulsed low during SHIFT -> an = 8'hFF, seg = 7'h7F immediately (asynchronously); after release display blank until first COMMIT, then correct.
REQ-032 Any frame -> an one-hot-low sequence 0..7, each digit active exactly DIV cycles.
